// File: rtl/serial_tx8.sv
// Purpose : 8N1 serial transmitter: one parallel byte in, start bit, 8 data bits LSB first, stop bit out.
// Latency : tx/busy change on the edge that accepts load; a frame lasts 10*CLKS_PER_BIT cycles, then done pulses.
// Backpr. : load is sampled only in IDLE, so load/d are ignored while busy; back-to-back loads are accepted in the done cycle.
//
// Ports:
//   clk    - single clock, all state changes on its rising edge
//   reset  - synchronous, active-low
//   load   - frame start request, level-sensitive, sampled in IDLE only
//   d      - parallel byte, captured on the edge that accepts load
//   tx     - registered serial line, idles high
//   busy   - high while a frame is in progress
//   done   - one-cycle pulse when a frame completes

module serial_tx8 #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] d,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // Last count value of a bit period; the counter wraps to 0 after it.
    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);

    state_t     state;
    logic [7:0] bit_cnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;

    // High on the final cycle of the current bit period.
    logic       bit_end;
    assign bit_end = (bit_cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            bit_cnt <= 8'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            // done is a single-cycle pulse; only the STOP exit raises it.
            done <= 1'b0;

            case (state)
                IDLE: begin
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    bit_cnt <= 8'd0;
                    bit_idx <= 3'd0;
                    if (load) begin
                        shreg <= d;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end

                START: begin
                    if (bit_end) begin
                        bit_cnt <= 8'd0;
                        bit_idx <= 3'd0;
                        state   <= DATA;
                        tx      <= shreg[0];
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end

                DATA: begin
                    if (bit_end) begin
                        bit_cnt <= 8'd0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            // Shift right so shreg[0] always holds the bit on the line;
                            // the next bit to send is therefore shreg[1].
                            bit_idx <= bit_idx + 3'd1;
                            shreg   <= {1'b0, shreg[7:1]};
                            tx      <= shreg[1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end

                STOP: begin
                    if (bit_end) begin
                        bit_cnt <= 8'd0;
                        state   <= IDLE;
                        tx      <= 1'b1;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end

                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    bit_cnt <= 8'd0;
                    bit_idx <= 3'd0;
                end
            endcase
        end
    end

endmodule
